// File: rtl/hdq_poll_sequencer.sv
// hdq_poll_sequencer: sweeps a table of 16-bit gauge registers through hdq_interface, one HDQ byte read
// per transaction, with timeout/retry, and hands each assembled word out on a valid/ready port.
module hdq_poll_sequencer #(
    parameter int         NUM_WORDS      = 4,
    parameter logic [7:0] ADDR0          = 8'h06,
    parameter logic [7:0] ADDR1          = 8'h08,
    parameter logic [7:0] ADDR2          = 8'h0A,
    parameter logic [7:0] ADDR3          = 8'h0C,
    parameter int         RST_HOLD_CYC   = 400,
    parameter int         START_HOLD_CYC = 400,
    parameter int         TIMEOUT_CYC    = 2_000_000,
    parameter int         MAX_RETRY      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        hdq_rst,
    output logic        hdq_start,
    output logic [7:0]  hdq_addr,
    input  logic        hdq_done,
    input  logic [7:0]  hdq_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [1:0]  word_idx,
    output logic [15:0] word_data,
    output logic        word_err,
    output logic        busy,
    output logic [7:0]  err_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_RST, S_ARM, S_START, S_WAIT, S_CAPTURE, S_OUT} state_t;

    localparam logic [23:0] RST_LD   = 24'(RST_HOLD_CYC - 1);
    localparam logic [23:0] START_LD = 24'(START_HOLD_CYC - 1);
    localparam logic [23:0] WAIT_LD  = 24'(TIMEOUT_CYC - START_HOLD_CYC - 1);
    localparam logic [1:0]  LAST     = 2'(NUM_WORDS - 1);
    localparam logic [3:0]  RMAX     = 4'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [23:0] tmr_q, tmr_d;
    logic [1:0]  idx_q, idx_d;
    logic        bsel_q, bsel_d;
    logic [3:0]  retry_q, retry_d;
    logic [7:0]  lsb_q, lsb_d, msb_q, msb_d, ecnt_q, ecnt_d;
    logic        werr_q, werr_d, skip_q, skip_d;
    logic [7:0]  addr_base, cap_byte;

    assign addr_base  = idx_q == 2'd0 ? ADDR0 : idx_q == 2'd1 ? ADDR1 : idx_q == 2'd2 ? ADDR2 : ADDR3;
    assign hdq_addr   = state_q == S_IDLE ? 8'h00 : addr_base + {7'b0, bsel_q};
    assign hdq_rst    = state_q == S_IDLE || state_q == S_RST || state_q == S_OUT;
    assign hdq_start  = state_q == S_START;
    assign word_valid = state_q == S_OUT;
    assign busy       = state_q != S_IDLE;
    assign word_idx   = idx_q;
    assign word_err   = werr_q;
    assign word_data  = werr_q ? 16'hFFFF : {msb_q, lsb_q};
    assign err_cnt    = ecnt_q;
    // an exhausted byte is captured as 0xFF without looking at the interface
    assign cap_byte   = skip_q ? 8'hFF : hdq_data;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q == 24'd0 ? 24'd0 : tmr_q - 24'd1;
        idx_d   = idx_q;
        bsel_d  = bsel_q;
        retry_d = retry_q;
        lsb_d   = lsb_q;
        msb_d   = msb_q;
        ecnt_d  = ecnt_q;
        werr_d  = werr_q;
        skip_d  = skip_q;
        case (state_q)
            S_IDLE: if (enable) begin
                state_d = S_RST;
                tmr_d   = RST_LD;
                idx_d   = 2'd0;
                bsel_d  = 1'b0;
                retry_d = 4'd0;
                werr_d  = 1'b0;
            end
            S_RST: if (tmr_q == 24'd0) state_d = S_ARM;
            S_ARM: if (!hdq_done) begin
                state_d = S_START;
                tmr_d   = START_LD;
            end
            S_START: if (tmr_q == 24'd0) begin
                state_d = S_WAIT;
                tmr_d   = WAIT_LD;
            end
            S_WAIT: if (hdq_done) begin
                state_d = S_CAPTURE;
                skip_d  = 1'b0;
            end else if (tmr_q == 24'd0) begin
                ecnt_d = ecnt_q == 8'hFF ? 8'hFF : ecnt_q + 8'd1;
                if (retry_q < RMAX) begin
                    retry_d = retry_q + 4'd1;
                    state_d = S_RST;
                    tmr_d   = RST_LD;
                end else begin
                    werr_d  = 1'b1;
                    skip_d  = 1'b1;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                lsb_d   = bsel_q ? lsb_q : cap_byte;
                msb_d   = bsel_q ? cap_byte : msb_q;
                retry_d = 4'd0;
                skip_d  = 1'b0;
                bsel_d  = 1'b1;
                state_d = bsel_q ? S_OUT : S_RST;
                tmr_d   = RST_LD;
            end
            S_OUT: if (word_ready) begin
                werr_d = 1'b0;
                if (idx_q == LAST || !enable) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    bsel_d  = 1'b0;
                    state_d = S_RST;
                    tmr_d   = RST_LD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmr_q   <= 24'd0;
            idx_q   <= 2'd0;
            bsel_q  <= 1'b0;
            retry_q <= 4'd0;
            lsb_q   <= 8'd0;
            msb_q   <= 8'd0;
            ecnt_q  <= 8'd0;
            werr_q  <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            bsel_q  <= bsel_d;
            retry_q <= retry_d;
            lsb_q   <= lsb_d;
            msb_q   <= msb_d;
            ecnt_q  <= ecnt_d;
            werr_q  <= werr_d;
            skip_q  <= skip_d;
        end
    end
endmodule

// File: tb/tb_hdq_poll_sequencer.sv
// tb_hdq_poll_sequencer: randomized bench with an HDQ slave model and a word-level reference of the sweep.
module tb_hdq_poll_sequencer;
    logic        clk = 0, rst_n = 0, enable = 0, word_ready = 0;
    logic        hdq_rst, hdq_start, hdq_done = 0, word_valid, word_err, busy;
    logic [7:0]  hdq_addr, hdq_data = 0, err_cnt;
    logic [1:0]  word_idx;
    logic [15:0] word_data;

    hdq_poll_sequencer #(.RST_HOLD_CYC(8), .START_HOLD_CYC(6), .TIMEOUT_CYC(60)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .hdq_rst(hdq_rst), .hdq_start(hdq_start),
        .hdq_addr(hdq_addr), .hdq_done(hdq_done), .hdq_data(hdq_data), .word_valid(word_valid),
        .word_ready(word_ready), .word_idx(word_idx), .word_data(word_data), .word_err(word_err),
        .busy(busy), .err_cnt(err_cnt));

    always #5 clk = ~clk;

    typedef struct {logic [1:0] idx; logic [15:0] data; logic err;} word_t;
    logic [7:0] addr_tab [4] = '{8'h06, 8'h08, 8'h0A, 8'h0C};
    logic [7:0] mem [128];
    int         mute [256];
    logic [7:0] log_q [$];
    logic [7:0] exp_a [$];
    word_t      exp_w [$];
    int         exp_errcnt = 0, errors = 0, checks = 0, viol = 0, pend = 0;
    logic       st_prev = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // slave: sticky done cleared by hdq_rst, answers a start after a delay unless muted
    always @(posedge clk) begin
        st_prev <= hdq_start;
        if (hdq_start && (hdq_rst || hdq_done)) viol = viol + 1;
        if (hdq_rst) begin
            hdq_done <= 0;
            pend = 0;
        end else if (hdq_start && !st_prev) begin
            log_q.push_back(hdq_addr);
            if (mute[hdq_addr] > 0) mute[hdq_addr] = mute[hdq_addr] - 1;
            else pend = $urandom_range(8, 40);
        end else if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                hdq_done <= 1;
                hdq_data <= mem[hdq_addr[6:0]];
            end
        end
    end

    function automatic void predict(input int nw);
        int mm [256];
        logic [7:0] a, v;
        logic [15:0] d;
        logic e;
        bit ok;
        word_t w;
        mm = mute;
        for (int i = 0; i < nw; i++) begin
            e = 0;
            d = 0;
            for (int b = 0; b < 2; b++) begin
                a = addr_tab[i] + 8'(b);
                v = 8'hFF;
                ok = 0;
                for (int t = 0; t <= 2 && !ok; t++) begin
                    exp_a.push_back(a);
                    if (mm[a] > 0) begin
                        mm[a]--;
                        exp_errcnt = exp_errcnt < 255 ? exp_errcnt + 1 : 255;
                    end else begin
                        ok = 1;
                        v = mem[a[6:0]];
                    end
                end
                if (!ok) e = 1;
                d[b*8 +: 8] = v;
            end
            w.idx = 2'(i);
            w.data = e ? 16'hFFFF : d;
            w.err = e;
            exp_w.push_back(w);
        end
    endfunction

    task automatic sweep(input int nw, input int rmode, input bit hold, input bit early);
        int got = 0, budget = 0, hs, bad, n;
        bit held = 0;
        logic [15:0] hd;
        logic [1:0] hi;
        word_t w;
        predict(nw);
        log_q.delete();
        enable = 1;
        while (got < nw && budget < 20000) begin
            @(negedge clk);
            budget++;
            if (early && busy) enable = 0;
            if (word_valid && hold && !held) begin
                word_ready = 0;
                hd = word_data;
                hi = word_idx;
                hs = log_q.size();
                bad = 0;
                repeat (1000) begin
                    @(negedge clk);
                    if (!word_valid || word_data !== hd || word_idx !== hi) bad++;
                end
                check("hold_stable", bad, 0);
                check("hold_no_start", log_q.size(), hs);
                held = 1;
            end
            word_ready = rmode == 0 ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (word_valid && word_ready) begin
                if (exp_w.size() == 0) check("extra_word", 1, 0);
                else begin
                    w = exp_w.pop_front();
                    check("word_idx", word_idx, w.idx);
                    check("word_data", word_data, w.data);
                    check("word_err", word_err, w.err);
                end
                got++;
                if (got == nw) enable = 0;
            end
        end
        check("sweep_words", got, nw);
        @(negedge clk);
        word_ready = 0;
        check("idle_after_sweep", busy, 0);
        check("idle_hdq_rst", hdq_rst, 1);
        check("err_cnt", err_cnt, exp_errcnt);
        check("start_count", log_q.size(), exp_a.size());
        n = log_q.size() < exp_a.size() ? log_q.size() : exp_a.size();
        for (int i = 0; i < n; i++) check("start_addr", log_q[i], exp_a[i]);
        exp_a.delete();
        exp_w.delete();
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mute[i] = 0;
    endtask

    initial begin
        int k;
        randomize_mem();
        repeat (3) @(negedge clk);
        check("rst_hdq_rst", hdq_rst, 1);
        check("rst_start", hdq_start, 0);
        check("rst_valid", word_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_addr", hdq_addr, 0);
        check("rst_data", {word_idx, word_err, word_data}, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);
        mem[6] = 8'h34;
        mem[7] = 8'h12;
        sweep(4, 0, 0, 0);
        randomize_mem();
        sweep(4, 1, 1, 0);
        randomize_mem();
        mute[8'h09] = 3;
        sweep(4, 1, 0, 0);
        randomize_mem();
        mute[8'h0A] = 1;
        sweep(4, 0, 0, 0);
        randomize_mem();
        sweep(1, 1, 0, 1);
        for (int r = 0; r < 6; r++) begin
            randomize_mem();
            k = $urandom_range(0, 3);
            mute[8'h06 + k * 2 + $urandom_range(0, 1)] = $urandom_range(0, 4);
            mute[8'h06 + $urandom_range(0, 7)] = $urandom_range(0, 2);
            sweep(4, 1, 0, 0);
        end
        randomize_mem();
        mute[8'h06] = 1;
        log_q.delete();
        enable = 1;
        k = 0;
        while (log_q.size() == 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("abort_started", log_q.size(), 1);
        repeat (15) @(negedge clk);
        check("abort_busy_pre", busy, 1);
        rst_n = 0;
        enable = 0;
        #1;
        check("abort_hdq_rst", hdq_rst, 1);
        check("abort_busy", busy, 0);
        check("abort_start", hdq_start, 0);
        check("abort_err_cnt", err_cnt, 0);
        check("abort_word", {word_valid, word_idx, word_err, word_data}, 0);
        exp_errcnt = 0;
        @(negedge clk);
        rst_n = 1;
        randomize_mem();
        sweep(4, 1, 0, 0);
        check("start_rst_overlap", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
